rca_16: RTL and testbench
=========================

Name: rca_16

Overview:
- 16-bit ripple-carry adder: a + b + cin, with a combinational sum/carry-out path.
- Also provides an optional registered copy of the result for pipelined datapaths.
- The combinational path is a structural chain of full-adder cells, with carry rippling LSB to MSB.
- Used as the basic add primitive in datapath blocks; usable either as pure combinational logic or as a one-stage registered adder.

Parameters:
- WIDTH, 16, operand/sum width in bits. Only 16 is verified; the structure must remain width-generic.

Ports:
- clk  input  1  clock for the registered result stage.
- rst_n  input  1  asynchronous active-low reset; clears the registered stage only.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- s  output  WIDTH  combinational sum, equal to (a+b+cin) mod 2^WIDTH.
- co  output  1  combinational carry-out, bit WIDTH of a+b+cin.
- ovf  output  1  combinational signed overflow, equal to carry into MSB XOR carry out of MSB.
- en  input  1  capture enable for the registered stage.
- s_q  output  WIDTH  registered sum.
- co_q  output  1  registered carry-out.
- ovf_q  output  1  registered signed overflow.
- vld_q  output  1  high for the cycle after a capture (en=1); otherwise low.

Behaviour:
- Combinational path
  - {co, s} = a + b + cin, evaluated as a full (WIDTH+1)-bit result; no truncation before the carry-out is formed.
  - Built as WIDTH full-adder cells, where cell i computes s[i] = a[i]^b[i]^c[i] and c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]).
  - c[0] = cin; co = c[WIDTH].
  - ovf = c[WIDTH-1] ^ c[WIDTH].
  - Zero clock latency; outputs must settle within one test step (10 ns) of any input change.
  - Independent of clk, rst_n and en; reset does not affect s, co or ovf.
  - No X-propagation masking: outputs are purely a function of a, b and cin.
- Registered path
  - On rising clk with en=1: s_q<=s, co_q<=co, ovf_q<=ovf, vld_q<=1.
  - On rising clk with en=0: s_q, co_q and ovf_q hold their values; vld_q<=0.
  - rst_n low, asynchronously at any time including mid-operation: s_q=0, co_q=0, ovf_q=0, vld_q=0 immediately, held while rst_n is low.
  - First capture is possible on the first rising clk edge after rst_n deasserts.
  - Latency: 1 cycle from sampled inputs to registered outputs; throughput: 1 result per cycle.
- Wrap-around
  - The sum wraps modulo 2^16; the lost MSB appears only on co.
  - Example: 0xFFFF + 0xFFFF + 1 gives s=0xFFFF, co=1.
- cin is a single bit; there is no other carry source.

Test Plan:
- a=0x0000, b=0x0000, cin=0 -> s=0x0000, co=0, ovf=0.
- a=0xFFFF, b=0x0001, cin=0 -> s=0x0000, co=1, ovf=0.
- a=0xFFFF, b=0xFFFF, cin=1 -> s=0xFFFF, co=1, ovf=0 (full-length ripple).
- a=0x0001, b=0x0002, cin=1 -> s=0x0004, co=0. Then a=0xAAAA, b=0x5555, cin=0 -> s=0xFFFF, co=0. Then a=0x7FFF, b=0x0001, cin=0 -> s=0x8000, co=0, ovf=1.
- Registered path, checked against a+b+cin each time:
  - Randomised a/b/cin with en=1 each cycle -> s_q/co_q match the previous cycle's combinational result, and vld_q=1.
  - With en=0 -> s_q/co_q/ovf_q hold their values and vld_q=0.
- Assert rst_n low asynchronously between clock edges while s_q=0x0004 -> s_q/co_q/ovf_q/vld_q go to 0 immediately, with s/co unchanged. After release, the first en=1 edge loads the current sum.

Source files
------------

// File: rtl/rca_16.sv
// Ripple-carry adder: a full-adder chain with the carry running LSB to MSB,
// plus an optional one-stage registered copy of sum, carry-out and overflow.
module rca_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  input  logic             en,
  output logic [WIDTH-1:0] s_q,
  output logic             co_q,
  output logic             ovf_q,
  output logic             vld_q
);

  // w_c[i] is the carry into cell i; w_c[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;

  assign w_c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    logic w_p;
    assign w_p        = a[i] ^ b[i];
    assign w_s[i]     = w_p ^ w_c[i];
    assign w_c[i+1]   = (a[i] & b[i]) | (w_c[i] & w_p);
  end

  assign s   = w_s;
  assign co  = w_c[WIDTH];
  assign ovf = w_c[WIDTH-1] ^ w_c[WIDTH];

  // Handshake: vld_q is a valid-only strobe with no ready; it is high for
  // exactly the one cycle after an en=1 edge, and s_q/co_q/ovf_q carry the
  // result captured on that edge. Data holds between captures.
  logic [WIDTH-1:0] r_s;
  logic             r_co;
  logic             r_ovf;
  logic             r_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s   <= '0;
      r_co  <= 1'b0;
      r_ovf <= 1'b0;
      r_vld <= 1'b0;
    end else begin
      r_vld <= en;
      if (en) begin
        r_s   <= w_s;
        r_co  <= w_c[WIDTH];
        r_ovf <= w_c[WIDTH-1] ^ w_c[WIDTH];
      end
    end
  end

  assign s_q   = r_s;
  assign co_q  = r_co;
  assign ovf_q = r_ovf;
  assign vld_q = r_vld;

endmodule

// File: tb/tb_rca_16.sv
// Bench for rca_16: directed vectors check the combinational path as they are
// driven and queue the expected registered result for a separate monitor.
module tb_rca_16;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        en;
  logic [15:0] s;
  logic        co;
  logic        ovf;
  logic [15:0] s_q;
  logic        co_q;
  logic        ovf_q;
  logic        vld_q;

  int checks   = 0;
  int failures = 0;

  // {ovf, co, s}
  logic [17:0] exp_q[$];
  logic [17:0] last_val = '0;

  rca_16 #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .s     (s),
    .co    (co),
    .ovf   (ovf),
    .en    (en),
    .s_q   (s_q),
    .co_q  (co_q),
    .ovf_q (ovf_q),
    .vld_q (vld_q)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: bench did not reach its end");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input logic [18:0] act, input logic [18:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%05h expected 0x%05h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_vec(input logic [15:0] va, input logic [15:0] vb, input logic vcin,
                           input logic ven, input logic [15:0] es, input logic eco,
                           input logic eovf);
    @(negedge clk);
    a   = va;
    b   = vb;
    cin = vcin;
    en  = ven;
    #2;
    chk($sformatf("comb %04h+%04h+%0b", va, vb, vcin),
        {1'b0, ovf, co, s}, {1'b0, eovf, eco, es});
    if (ven) exp_q.push_back({eovf, eco, es});
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [17:0] exp_v;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) last_val = '0;
      if (vld_q) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL reg_unexpected_vld: got vld_q=1 s_q=0x%04h expected no capture", s_q);
        end else begin
          exp_v = exp_q.pop_front();
          chk("reg_capture", {1'b0, ovf_q, co_q, s_q}, {1'b0, exp_v});
          last_val = exp_v;
        end
      end else begin
        chk("reg_hold", {1'b0, ovf_q, co_q, s_q}, {1'b0, last_val});
        if (exp_q.size() != 0) begin
          checks++;
          failures++;
          exp_v = exp_q.pop_front();
          $display("FAIL reg_missing_vld: got vld_q=0 expected capture of 0x%05h", exp_v);
          last_val = exp_v;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    en    = 1'b0;
    #3;
    chk("reset_regs", {vld_q, ovf_q, co_q, s_q}, 19'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // captured vectors
    drive_vec(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    drive_vec(16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    drive_vec(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    // en=0: registered outputs must hold the last capture
    drive_vec(16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    drive_vec(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    drive_vec(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    // back-to-back captures
    drive_vec(16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0);
    drive_vec(16'h8000, 16'hFFFF, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    drive_vec(16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b1);
    drive_vec(16'h0F0F, 16'hF0F1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    drive_vec(16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
    drive_vec(16'h0001, 16'h0002, 1'b1, 1'b1, 16'h0004, 1'b0, 1'b0);

    // asynchronous reset between edges while s_q=0x0004
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_regs", {vld_q, ovf_q, co_q, s_q}, 19'h0);
    chk("async_reset_comb", {1'b0, ovf, co, s}, {1'b0, 1'b0, 1'b0, 16'h0004});
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // first capture after release
    drive_vec(16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
    drive_vec(16'hAAAA, 16'h5555, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    drive_vec(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending results expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
